seq_matcher: RTL
================

Name: seq_matcher

Overview:
Parametrised successor of the fixed four-bit sequence finder. It watches a qualified serial bit stream and compares the most recent seq_len bits, with a runtime length of 1..SEQUENCE_SIZE, against a programmable pattern. It reports each hit as a registered one-cycle pulse and keeps a saturating match count. It supports overlapping and non-overlapping detection and sits in the sequence-identifier path as a drop-in replacement wherever a fixed-width finder is used.

Parameters:
SEQUENCE_SIZE, 8, maximum pattern length in bits; must be at least 2.
COUNT_WIDTH, 8, width of match_count, and of the beat stamp when that feature is enabled.
LEN_W, $clog2(SEQUENCE_SIZE+1), width of seq_len; derived, do not override.

Ports:
clk  input  1  single clock; all logic on the rising edge.
rst_n  input  1  synchronous active-low reset.
serial_in  input  1  stream bit; sampled only when in_valid=1.
in_valid  input  1  qualifies serial_in for this cycle.
bit_sequence  input  SEQUENCE_SIZE  pattern; bit_sequence[0] is compared with the newest bit.
seq_len  input  LEN_W  active pattern length; 0 or >SEQUENCE_SIZE means SEQUENCE_SIZE.
overlap_en  input  1  1 = overlapping matches allowed; 0 = window restarts after each match.
clear  input  1  synchronous soft clear of history, state and count.
sqce_found  output  1  one-cycle pulse; registered.
match_count  output  COUNT_WIDTH  saturating number of matches since reset/clear.
armed  output  1  history holds at least eff_len valid bits (state ARMED).

Behaviour:
- Reset (rst_n=0 at edge): shift reg=0, fill_cnt=0, state=FILL, sqce_found=0, match_count=0, armed=0. clear=1 has the same effect. rst_n has priority over clear; clear has priority over in_valid.
- eff_len = (seq_len==0 || seq_len>SEQUENCE_SIZE) ? SEQUENCE_SIZE : seq_len.
- On in_valid=1: sr <= {sr[SEQUENCE_SIZE-2:0], serial_in}, so the newest bit lands in sr[0]. fill_cnt increments and saturates at SEQUENCE_SIZE.
- Cycles with in_valid=0: sr and fill_cnt hold; sqce_found=0.
- Match test uses the post-shift values sr_next and fill_next. A hit requires in_valid=1, fill_next>=eff_len, and sr_next[i]==bit_sequence[i] for all i<eff_len. Bits at or above eff_len are ignored.
- Latency: sqce_found=1 in the cycle after the edge that sampled the completing bit, for exactly one cycle per hit. Back-to-back valid hits give consecutive pulses.
- FSM, 2 states:
  - FILL (fill_cnt<eff_len): armed=0. Goes to ARMED when fill_next>=eff_len.
  - ARMED: armed=1.
  - On a hit with overlap_en=0: fill_cnt<=0 and state<=FILL. sr still shifts, but old bits cannot contribute to the next hit.
  - On a hit with overlap_en=1: stay in ARMED.
  - If eff_len changes to a value >fill_cnt: go to FILL on the next edge. No history is lost.
- seq_len, bit_sequence and overlap_en are sampled every cycle; changes take effect on the next valid bit.
- match_count increments on each hit and holds at 2^COUNT_WIDTH-1; it never wraps.
- eff_len=1: every valid bit equal to bit_sequence[0] is a hit, in either mode.

Optional Feature:
Macro SEQ_MATCHER_BEAT_STAMP_EN.
- Defined: adds output last_match_beat [COUNT_WIDTH-1:0] and an internal beat counter.
  - The beat counter increments on every in_valid, wraps modulo 2^COUNT_WIDTH, and resets to 0 on rst_n/clear.
  - On a hit, last_match_beat <= beat index of the completing bit, where the first valid bit after reset is index 0. Its update is simultaneous with sqce_found.
  - Resets to 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- SEQUENCE_SIZE=8, seq_len=4, bit_sequence[3:0]=4'b1011, overlap_en=1, stream 1,0,1,1,0,1,1 (oldest first) -> sqce_found pulses after bit 3 and after bit 6; match_count=2.
- Same stream with overlap_en=0 -> single pulse after bit 3; the window restarts, so bit 6 does not hit; match_count=1.
- Pattern 4'b1111, seq_len=4, overlap_en=1, seven consecutive 1s -> pulses on beats 3,4,5,6; with overlap_en=0 -> pulse only on beat 3.
- in_valid toggling 1,0,0,1,1,1 carrying the bits of 4'b1011 -> the idle cycles neither shift nor pulse; one pulse after the 4th valid bit.
- seq_len=0 with SEQUENCE_SIZE=8 -> acts as length 8; armed rises only after the 8th valid bit. Asserting clear mid-stream -> armed=0, match_count=0, and the next hit needs a full window.
- COUNT_WIDTH=2, five overlapping hits -> match_count saturates at 3. With SEQ_MATCHER_BEAT_STAMP_EN, last_match_beat equals the beat index of each hit.

Source files
------------

// File: rtl/seq_matcher.sv
// Serial pattern finder: compares the newest eff_len qualified bits against bit_sequence.
// Optional feature macro SEQ_MATCHER_BEAT_STAMP_EN adds last_match_beat.
module seq_matcher #(
  parameter int SEQUENCE_SIZE = 8,
  parameter int COUNT_WIDTH   = 8,
  parameter int LEN_W         = $clog2(SEQUENCE_SIZE + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     serial_in,
  input  logic                     in_valid,
  input  logic [SEQUENCE_SIZE-1:0] bit_sequence,
  input  logic [LEN_W-1:0]         seq_len,
  input  logic                     overlap_en,
  input  logic                     clear,
  output logic                     sqce_found,
  output logic [COUNT_WIDTH-1:0]   match_count,
  output logic                     armed
`ifdef SEQ_MATCHER_BEAT_STAMP_EN
  ,
  output logic [COUNT_WIDTH-1:0]   last_match_beat
`endif
);

  localparam logic [LEN_W-1:0]       SEQ_MAX   = LEN_W'(SEQUENCE_SIZE);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic {FILL, ARMED} state_t;

  state_t                   state, state_next;
  logic [SEQUENCE_SIZE-1:0] sr, sr_next;
  logic [LEN_W-1:0]         fill_cnt, fill_next, fill_upd;
  logic [LEN_W-1:0]         eff_len;
  logic                     pattern_ok;
  logic                     hit;

  // Out-of-range lengths fall back to the full window.
  always_comb begin
    eff_len = seq_len;
    if (seq_len == '0 || seq_len > SEQ_MAX) begin
      eff_len = SEQ_MAX;
    end
  end

  always_comb begin
    sr_next   = sr;
    fill_next = fill_cnt;
    if (in_valid) begin
      sr_next = {sr[SEQUENCE_SIZE-2:0], serial_in};
      if (fill_cnt != SEQ_MAX) begin
        fill_next = fill_cnt + LEN_W'(1);
      end
    end
  end

  // Bits at or above eff_len are masked out of the comparison.
  always_comb begin
    pattern_ok = 1'b1;
    for (int i = 0; i < SEQUENCE_SIZE; i++) begin
      if (LEN_W'(i) < eff_len && sr_next[i] != bit_sequence[i]) begin
        pattern_ok = 1'b0;
      end
    end
    hit = in_valid && (fill_next >= eff_len) && pattern_ok;
  end

  always_comb begin
    state_next = state;
    fill_upd   = fill_next;
    if (hit && !overlap_en) begin
      state_next = FILL;
      fill_upd   = '0;
    end else if (fill_next >= eff_len) begin
      state_next = ARMED;
    end else begin
      state_next = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state       <= FILL;
      sr          <= '0;
      fill_cnt    <= '0;
      sqce_found  <= 1'b0;
      match_count <= '0;
    end else begin
      state      <= state_next;
      sr         <= sr_next;
      fill_cnt   <= fill_upd;
      sqce_found <= hit;
      if (hit && match_count != COUNT_MAX) begin
        match_count <= match_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign armed = (state == ARMED);

`ifdef SEQ_MATCHER_BEAT_STAMP_EN
  logic [COUNT_WIDTH-1:0] beat_cnt;

  // Beat index counts every qualified bit and wraps; the hit stamps the completing beat.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      beat_cnt        <= '0;
      last_match_beat <= '0;
    end else begin
      if (in_valid) begin
        beat_cnt <= beat_cnt + COUNT_WIDTH'(1);
      end
      if (hit) begin
        last_match_beat <= beat_cnt;
      end
    end
  end
`endif

endmodule
